// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes common with the decode stage and
// the execution FSM state encoding.
// No logic; imported by alu_exec_unit and alu_mul_iter.
package alu_pkg;

  // 4-bit ALU control codes (must match the decode stage).
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  // Execution FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, low WIDTH bits of the unsigned product.
// Latency: loads on i_start, then one multiplier bit per edge for WIDTH edges.
// Backpressure: none; the caller only starts it when it can take the result.
// Ports: clk, rst_n; i_start/i_a/i_b load operands; o_done is high during the
// final iteration cycle, when o_result already holds the completed product.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  logic             r_busy;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // Expose the post-iteration sum so the top can register the product on the
  // same edge that performs the last iteration.
  assign o_result   = w_acc_next;
  assign o_done     = r_busy && (r_cnt == LAST_ITER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 6'd1;
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith/shift ops plus iterative MUL.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL.
// Backpressure: result held until out_ready; in_ready only when slot frees.
// Ports: in_valid/in_ready/alu_ctrl/op_a/op_b request side;
// out_valid/out_ready/result/zero/err response side; clk, rst_n.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_t           r_state;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_done;
  logic             w_sc_err;
  logic [WIDTH-1:0] w_sc_res;
  logic [WIDTH-1:0] w_mul_res;
  logic [SHW-1:0]   w_shamt;

  // DONE with out_ready frees the output slot in the same cycle, which lets
  // single-cycle ops stream at one per clock.
  assign in_ready    = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = (alu_ctrl == ALU_MUL);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_shamt     = op_b[SHW-1:0];

  always_comb begin
    w_sc_res = '0;
    w_sc_err = 1'b0;
    case (alu_ctrl)
      ALU_AND: w_sc_res = op_a & op_b;
      ALU_OR:  w_sc_res = op_a | op_b;
      ALU_ADD: w_sc_res = op_a + op_b;
      ALU_SUB: w_sc_res = op_a - op_b;
      ALU_XOR: w_sc_res = op_a ^ op_b;
      ALU_SLT: w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLL: w_sc_res = op_a << w_shamt;
      ALU_SRL: w_sc_res = op_a >> w_shamt;
      default: w_sc_err = 1'b1;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_mul_start),
    .i_a      (op_a),
    .i_b      (op_b),
    .o_done   (w_mul_done),
    .o_result (w_mul_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state   <= BUSY;
              out_valid <= 1'b0;
            end else begin
              r_state   <= DONE;
              out_valid <= 1'b1;
              result    <= w_sc_res;
              zero      <= (w_sc_res == '0);
              err       <= w_sc_err;
            end
          end else if ((r_state == DONE) && out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (w_mul_done) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            result    <= w_mul_res;
            zero      <= (w_mul_res == '0);
            err       <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors with literal
// expectations plus a scoreboard fed by an operation-level reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_ctrl = 4'h0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         err;

  int n_checks = 0;
  int n_err    = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } exp_t;

  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    logic [4:0]  sh;
    sh    = b[4:0];
    e.res = '0;
    e.err = 1'b0;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0011: e.res = a ^ b;
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100: e.res = a << sh;
      4'b0101: e.res = a >> sh;
      4'b1000: begin
        p     = {32'b0, a} * {32'b0, b};
        e.res = p[31:0];
      end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  exp_t         sb[$];
  logic         hold = 1'b0;
  logic [W-1:0] h_res;
  logic         h_zero, h_err;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_result", result, h_res);
        chk("hold_flags", {30'b0, zero, err}, {30'b0, h_zero, h_err});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected: result %h delivered with no pending op", result);
        end else begin
          e = sb.pop_front();
          chk("sb_result", result, e.res);
          chk("sb_zero", {31'b0, zero}, {31'b0, e.zero});
          chk("sb_err", {31'b0, err}, {31'b0, e.err});
        end
      end
      hold   = out_valid && !out_ready;
      h_res  = result;
      h_zero = zero;
      h_err  = err;
      if (in_valid && in_ready) sb.push_back(model(alu_ctrl, op_a, op_b));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op1(input string name, input logic [3:0] c, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] er, input logic ez, input logic ee);
    in_valid  = 1'b1;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a     = '1;
    op_b     = '1;
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_result"}, result, er);
    chk({name, "_flags"}, {30'b0, zero, err}, {30'b0, ez, ee});
    tick();
    chk({name, "_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic mul_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er);
    int busy;
    in_valid  = 1'b1;
    alu_ctrl  = 4'b1000;
    op_a      = a;
    op_b      = b;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    alu_ctrl = 4'b0010;
    op_a     = 32'h1234;
    busy     = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) break;
      busy++;
      tick();
    end
    chk({name, "_busy_cycles"}, busy, 32'd32);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_result"}, result, er);
    tick();
    chk({name, "_one_cycle"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    // Reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'b0, zero, err}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Single-cycle ops
    op1("add", 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    op1("sub_zero", 4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
    op1("sub_wrap", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    op1("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    op1("slt_pos", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    op1("sll_max", 4'b0100, 32'd1, 32'h3F, 32'h8000_0000, 1'b0, 1'b0);
    op1("srl", 4'b0101, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, 1'b0);
    op1("bad_code", 4'b1111, 32'h55, 32'hAA, 32'd0, 1'b1, 1'b1);

    // Iterative multiply
    mul_op("mul", 32'h0001_0000, 32'h0001_0001, 32'h0001_0000);
    mul_op("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    // Back-to-back streaming
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_a      = 32'hF0F0;
    op_b      = 32'h0FF0;
    alu_ctrl  = 4'b0000;
    tick();
    chk("b2b_and", result, 32'h0000_00F0);
    chk("b2b_and_v", {31'b0, out_valid}, 32'd1);
    alu_ctrl = 4'b0001;
    tick();
    chk("b2b_or", result, 32'h0000_FFF0);
    alu_ctrl = 4'b0011;
    tick();
    chk("b2b_xor", result, 32'h0000_FF00);
    in_valid = 1'b0;
    tick();
    chk("b2b_drop", {31'b0, out_valid}, 32'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0010;
    op_a      = 32'd1;
    op_b      = 32'd1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result", result, 32'd2);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0100;
    op_a      = 32'd1;
    op_b      = 32'd4;
    #1;
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_sll_result", result, 32'd16);
    chk("bp_sll_valid", {31'b0, out_valid}, 32'd1);
    tick();

    // Reset during MUL
    in_valid = 1'b1;
    alu_ctrl = 4'b1000;
    op_a     = 32'd3;
    op_b     = 32'd5;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_result", result, 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("abort_no_result", seen, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU decode stage.
- Accepts operands plus control code over a valid/ready handshake and returns a registered result, zero flag and error flag over a second valid/ready handshake.
- Single-cycle ops (AND/OR/ADD/SUB/XOR/SLT/SLL/SRL) finish one cycle after acceptance. MUL is iterative shift-add and takes WIDTH cycles.
- Sits between the register-read stage and writeback. It is the path for stall-capable execution in the processor.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2 and a power of two.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and code valid
- in_ready  output  1  unit can accept; combinational
- alu_ctrl  input  4  operation code
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- err  output  1  unsupported alu_ctrl code

Behaviour:
- Interface clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0011 XOR
  - 0111 SLT (signed, result 1 or 0)
  - 0100 SLL by op_b[log2(WIDTH)-1:0]
  - 0101 SRL (logical) by the same field
  - 1000 MUL (low WIDTH bits of unsigned product)
  - Any other code: result=0, err=1, zero=1. It completes as a single-cycle op.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- FSM states and transitions:
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → BUSY on accept of MUL.
  - BUSY → DONE after the WIDTH-th iteration.
  - DONE → IDLE on out_ready when no new accept occurs in that cycle.
  - DONE → DONE or BUSY on out_ready with a simultaneous accept.
- Accept occurs at a rising edge where in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back single-cycle ops one result per cycle.
- Latency:
  - Single-cycle op accepted at edge N: out_valid high from edge N, i.e. visible in cycle N+1.
  - MUL accepted at edge N: multiplicand, multiplier and accumulator load at N. One bit is processed per edge, and a 6-bit counter tracks iterations. out_valid rises after edge N+WIDTH.
- In BUSY: in_ready=0, out_valid=0, and inputs are ignored.
- result, zero and err hold stable while out_valid && !out_ready. They change only on a new completion.
- Inputs are captured at accept. op_a, op_b and alu_ctrl may change afterwards with no effect.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, err=0, counter=0, accumulator=0. in_ready reads 1 during and after reset.
- Reset mid-MUL aborts the operation; no result is ever emitted for it.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for all 4-bit alu_ctrl codes, shared with the decode stage
  - the FSM state encoding IDLE/BUSY/DONE (2 bits)
- One sub-module: alu_mul_iter. It contains the shift-add datapath: start, busy, done, WIDTH-bit accumulator and counter.
- The top level contains the FSM, the single-cycle datapath and the output registers.

Test Plan:
- Reset then ADD op_a=5, op_b=7, out_ready=1 → out_valid one cycle after accept, result=12, zero=0, err=0.
- SUB 3−3 → result=0, zero=1. SUB 0−1 → result=0xFFFFFFFF. SLT op_a=0xFFFFFFFF, op_b=1 → result=1.
- MUL 0x10000×0x10001 with out_ready=1 → in_ready=0 for exactly 32 cycles, then result=0x00010000 (low 32 bits), out_valid high for one cycle.
- Back-to-back: in_valid held, out_ready=1, sequence AND/OR/XOR on 0xF0F0,0x0FF0 → results 0x00F0, 0xFFF0, 0xFF00 on three consecutive cycles.
- Backpressure: ADD 1+1 completes with out_ready=0 for 4 cycles → result=2 stays stable, in_ready=0. Then out_ready=1 with simultaneous SLL 1<<4 → next result=16.
- Code 1111 → err=1, result=0, zero=1. MUL started and rst_n pulsed low at iteration 10 → out_valid stays 0, in_ready=1, and result=0 immediately.
